q_episode_ctrl: RTL and testbench
=================================

Q_EPISODE_CTRL -- requirements
Module: q_episode_ctrl

Interface
REQ-001 Parameter NUM_EPISODES, default 100: episodes per training run (1..65535).
REQ-002 Parameter MAX_STEPS, default 64: step limit per episode (1..255).
REQ-003 Parameter START_STATE, default 1: maze cell each episode begins in.
REQ-004 Parameter GOAL_STATE, default 36: terminal maze cell.
REQ-005 Ports, one per line:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; begin a training run from IDLE.
- abort  in  1  level; cancel the run.
- act_valid  in  1  action selector has a valid action.
- action  in  4  selected action (0..3).
- step_done  in  1  step datapath result ready, single-cycle pulse.
- next_state  in  6  step datapath result cell.
- act_req  out  1  request action for maze_state.
- step_req  out  1  single-cycle pulse that launches a datapath step.
- action_q  out  4  latched action driven to the datapath.
- maze_state  out  6  current cell.
- loop_start  out  1  single-cycle pulse that reloads the original Q-table (first episode only).
- trial_stop  out  1  single-cycle pulse at episode end; freezes the datapath.
- episode_count  out  16  completed episodes.
- step_count  out  8  steps taken in the current episode.
- busy  out  1  high in every state except IDLE and FINISH.
- done  out  1  high in FINISH.
- err  out  1  sticky; an out-of-range next_state was seen.

Function
REQ-006 FSM states: IDLE, INIT, REQ_ACT, STEP, WAIT, UPDATE, EP_END, FINISH.
REQ-007 IDLE: all pulses low; start=1 -> INIT, and episode_count and err clear to 0.
REQ-008 INIT (1 cycle): maze_state<=START_STATE; step_count<=0; loop_start=1 only if episode_count==0; -> REQ_ACT.
REQ-009 REQ_ACT: act_req=1, held until act_valid=1; on that edge action_q<=action -> STEP.
REQ-010 STEP (1 cycle): step_req=1 -> WAIT.
REQ-011 WAIT: hold until step_done=1; next_state is sampled on the same edge -> UPDATE.
REQ-012 UPDATE (1 cycle):
- next_state in 1..36: maze_state<=next_state.
- next_state 0 or >36: maze_state unchanged and err<=1.
- step_count<=step_count+1 in both cases.
REQ-013 UPDATE exit: new maze_state==GOAL_STATE or step_count+1==MAX_STEPS -> EP_END; otherwise -> REQ_ACT. Goal takes precedence when both hold.
REQ-014 EP_END (1 cycle): trial_stop=1; episode_count<=episode_count+1; -> FINISH if episode_count+1==NUM_EPISODES, else -> INIT.
REQ-015 FINISH: done=1; leave to IDLE only when start=0. A start held high does not retrigger a run.
REQ-016 abort=1 in any state other than IDLE -> IDLE on the next edge. Counters and maze_state hold; no pulse is emitted on that edge.
REQ-017 act_valid and step_done are ignored outside REQ_ACT and WAIT respectively.
REQ-018 Latency per step with zero-wait handshakes: 4 cycles (REQ_ACT, STEP, WAIT, UPDATE).
REQ-019 Counters do not wrap: episode_count saturates at NUM_EPISODES; step_count saturates at MAX_STEPS.

Reset
REQ-020 rst=0 asynchronously forces:
- state to IDLE;
- maze_state to START_STATE;
- action_q, episode_count, step_count and err to 0;
- all pulse outputs, busy and done to 0.
REQ-021 Deassertion of rst mid-run restarts nothing; a new start is required.

Structure
REQ-022 Shared package q_pkg holds:
- the state enum typedef;
- constants MAZE_CELLS=36 and ACT_UP/ACT_RIGHT/ACT_DOWN/ACT_LEFT = 0..3;
- default START_STATE and GOAL_STATE.
REQ-023 Single module; no sub-module. The state register and counters live in one sequential process; outputs are decoded from state.

Verification
REQ-024 NUM_EPISODES=1; start; act_valid tied high; step_done one cycle after step_req with next_state 7,13,19,25,31,36 -> trial_stop after 6th UPDATE, step_count=6, episode_count=1, done=1.
REQ-025 MAX_STEPS=4; next_state always 2 -> EP_END after 4 steps, step_count=4, maze_state=2, trial_stop pulsed once.
REQ-026 NUM_EPISODES=3 -> loop_start pulses exactly once (first INIT); trial_stop pulses 3 times; episode_count=3; done=1.
REQ-027 next_state=0 then 40 -> maze_state stays 1, err=1 sticky, step_count=2.
REQ-028 abort asserted in WAIT -> IDLE next cycle, busy=0, no trial_stop; rst=0 in UPDATE -> all outputs at reset values immediately (asynchronous).
REQ-029 Goal reached on step MAX_STEPS -> single EP_END, episode_count +1 exactly.

Source files
------------

// File: rtl/q_pkg.sv
// Shared types and constants for the Q-learning episode controller.
package q_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StReqAct,
    StStep,
    StWait,
    StUpdate,
    StEpEnd,
    StFinish
  } state_e;

  localparam int unsigned MAZE_CELLS = 36;

  localparam logic [3:0] ACT_UP    = 4'd0;
  localparam logic [3:0] ACT_RIGHT = 4'd1;
  localparam logic [3:0] ACT_DOWN  = 4'd2;
  localparam logic [3:0] ACT_LEFT  = 4'd3;

  localparam int unsigned DEFAULT_START_STATE = 1;
  localparam int unsigned DEFAULT_GOAL_STATE  = 36;

endpackage

// File: rtl/q_episode_ctrl.sv
// Episode/step sequencer for a maze Q-learning datapath: requests actions,
// launches steps, tracks the current cell and counts steps and episodes.
module q_episode_ctrl
  import q_pkg::*;
#(
  parameter int unsigned NUM_EPISODES = 100,
  parameter int unsigned MAX_STEPS    = 64,
  parameter int unsigned START_STATE  = DEFAULT_START_STATE,
  parameter int unsigned GOAL_STATE   = DEFAULT_GOAL_STATE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        act_valid,
  input  logic [3:0]  action,
  input  logic        step_done,
  input  logic [5:0]  next_state,
  output logic        act_req,
  output logic        step_req,
  output logic [3:0]  action_q,
  output logic [5:0]  maze_state,
  output logic        loop_start,
  output logic        trial_stop,
  output logic [15:0] episode_count,
  output logic [7:0]  step_count,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] NumEp   = 16'(NUM_EPISODES);
  localparam logic [7:0]  MaxSt   = 8'(MAX_STEPS);
  localparam logic [5:0]  StartSt = 6'(START_STATE);
  localparam logic [5:0]  GoalSt  = 6'(GOAL_STATE);
  localparam logic [5:0]  Cells   = 6'(MAZE_CELLS);

  state_e     state_q, state_d;
  logic [5:0] ns_q;
  logic [5:0] upd_state;
  logic       ns_ok, at_goal, last_step, last_ep, aborting;

  always_comb begin
    aborting  = abort && (state_q != StIdle);
    ns_ok     = (ns_q != 6'd0) && (ns_q <= Cells);
    // An out-of-range result leaves the agent where it was.
    upd_state = ns_ok ? ns_q : maze_state;
    at_goal   = (upd_state == GoalSt);
    last_step = (step_count >= MaxSt - 8'd1);
    last_ep   = (episode_count >= NumEp - 16'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      maze_state    <= StartSt;
      action_q      <= 4'd0;
      episode_count <= 16'd0;
      step_count    <= 8'd0;
      err           <= 1'b0;
      ns_q          <= 6'd0;
    end else begin
      state_q <= state_d;
      if (!aborting) begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              episode_count <= 16'd0;
              err           <= 1'b0;
            end
          end
          StInit: begin
            maze_state <= StartSt;
            step_count <= 8'd0;
          end
          StReqAct: if (act_valid) action_q <= action;
          StWait:   if (step_done) ns_q <= next_state;
          StUpdate: begin
            maze_state <= upd_state;
            if (!ns_ok) err <= 1'b1;
            if (step_count != MaxSt) step_count <= step_count + 8'd1;
          end
          StEpEnd: if (episode_count != NumEp) episode_count <= episode_count + 16'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (aborting) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (start) state_d = StInit;
        StInit:   state_d = StReqAct;
        StReqAct: if (act_valid) state_d = StStep;
        StStep:   state_d = StWait;
        StWait:   if (step_done) state_d = StUpdate;
        StUpdate: state_d = (at_goal || last_step) ? StEpEnd : StReqAct;
        StEpEnd:  state_d = last_ep ? StFinish : StInit;
        StFinish: if (!start) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Handshake outputs are suppressed while an abort is being taken.
  always_comb begin
    act_req    = (state_q == StReqAct) && !abort;
    step_req   = (state_q == StStep) && !abort;
    loop_start = (state_q == StInit) && (episode_count == 16'd0) && !abort;
    trial_stop = (state_q == StEpEnd) && !abort;
    busy       = (state_q != StIdle) && (state_q != StFinish);
    done       = (state_q == StFinish);
  end

endmodule

// File: tb/tb_q_episode_ctrl.sv
// Directed bench: one single-episode instance and one 3-episode/4-step instance.
module tb_q_episode_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Instance A: NUM_EPISODES=1, MAX_STEPS=64
  logic        start_a = 0, abort_a = 0, en_a = 1, prev_a = 0;
  logic        sd_a = 0;
  logic [5:0]  ns_a = 0;
  logic [5:0]  tab_a [8];
  logic        areq_a, sreq_a, ls_a, ts_a, busy_a, done_a, err_a;
  logic [3:0]  actq_a;
  logic [5:0]  maze_a;
  logic [15:0] ep_a;
  logic [7:0]  sc_a;
  int          n_ts_a = 0, n_ls_a = 0;

  q_episode_ctrl #(.NUM_EPISODES(1), .MAX_STEPS(64)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .act_valid(1'b1),
    .action(4'd2), .step_done(sd_a), .next_state(ns_a), .act_req(areq_a),
    .step_req(sreq_a), .action_q(actq_a), .maze_state(maze_a), .loop_start(ls_a),
    .trial_stop(ts_a), .episode_count(ep_a), .step_count(sc_a), .busy(busy_a),
    .done(done_a), .err(err_a)
  );

  // Instance B: NUM_EPISODES=3, MAX_STEPS=4
  logic        start_b = 0, prev_b = 0;
  logic        sd_b = 0;
  logic [5:0]  ns_b = 0;
  logic [5:0]  tab_b [8];
  logic        areq_b, sreq_b, ls_b, ts_b, busy_b, done_b, err_b;
  logic [3:0]  actq_b;
  logic [5:0]  maze_b;
  logic [15:0] ep_b;
  logic [7:0]  sc_b;
  int          n_ts_b = 0, n_ls_b = 0;

  q_episode_ctrl #(.NUM_EPISODES(3), .MAX_STEPS(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .act_valid(1'b1),
    .action(4'd3), .step_done(sd_b), .next_state(ns_b), .act_req(areq_b),
    .step_req(sreq_b), .action_q(actq_b), .maze_state(maze_b), .loop_start(ls_b),
    .trial_stop(ts_b), .episode_count(ep_b), .step_count(sc_b), .busy(busy_b),
    .done(done_b), .err(err_b)
  );

  // Datapath models: step_done one cycle after step_req, result indexed by step number.
  always @(negedge clk) begin
    sd_a   = prev_a && en_a;
    prev_a = sreq_a;
    ns_a   = tab_a[sc_a[2:0]];
    if (ts_a) n_ts_a++;
    if (ls_a) n_ls_a++;
  end

  always @(negedge clk) begin
    sd_b   = prev_b;
    prev_b = sreq_b;
    ns_b   = tab_b[sc_b[2:0]];
    if (ts_b) n_ts_b++;
    if (ls_b) n_ls_b++;
  end

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (!done_a && n < 300) begin tick(); n++; end
    check(tag, 32'(done_a), 1);
  endtask

  task automatic wait_done_b(input string tag);
    int n = 0;
    while (!done_b && n < 300) begin tick(); n++; end
    check(tag, 32'(done_b), 1);
  endtask

  task automatic pulse_start_a();
    start_a = 1; tick(); start_a = 0;
  endtask

  task automatic pulse_start_b();
    start_b = 1; tick(); start_b = 0;
  endtask

  int ts0, ls0, n;

  initial begin
    for (int i = 0; i < 8; i++) begin tab_a[i] = 6'd2; tab_b[i] = 6'd2; end
    #12;
    check("rst_maze",  32'(maze_a), 1);
    check("rst_ep",    32'(ep_a), 0);
    check("rst_busy",  32'(busy_a), 0);
    check("rst_done",  32'(done_a), 0);
    check("rst_areq",  32'(areq_a), 0);
    rst = 1;
    tick(); tick();
    check("idle_busy", 32'(busy_a), 0);

    // A: six steps reaching the goal on the sixth UPDATE
    tab_a[0] = 7; tab_a[1] = 13; tab_a[2] = 19; tab_a[3] = 25; tab_a[4] = 31; tab_a[5] = 36;
    ts0 = n_ts_a; ls0 = n_ls_a;
    pulse_start_a();
    check("a_busy_run", 32'(busy_a), 1);
    wait_done_a("a_goal_done");
    check("a_goal_sc",    32'(sc_a), 6);
    check("a_goal_ep",    32'(ep_a), 1);
    check("a_goal_maze",  32'(maze_a), 36);
    check("a_goal_ts",    32'(n_ts_a - ts0), 1);
    check("a_goal_ls",    32'(n_ls_a - ls0), 1);
    check("a_goal_actq",  32'(actq_a), 2);
    check("a_goal_busy",  32'(busy_a), 0);
    check("a_goal_err",   32'(err_a), 0);
    tick();
    check("a_finish_idle", 32'(done_a), 0);

    // A: out-of-range results 0 and 40, then the goal
    tab_a[0] = 0; tab_a[1] = 40; tab_a[2] = 36;
    pulse_start_a();
    n = 0;
    while (sc_a != 8'd2 && n < 100) begin tick(); n++; end
    check("a_bad_sc",   32'(sc_a), 2);
    check("a_bad_maze", 32'(maze_a), 1);
    check("a_bad_err",  32'(err_a), 1);
    wait_done_a("a_bad_done");
    check("a_bad_sticky", 32'(err_a), 1);
    check("a_bad_end_sc", 32'(sc_a), 3);
    tick();
    pulse_start_a();
    check("a_err_clear", 32'(err_a), 0);
    wait_done_a("a_rerun_done");
    tick();

    // A: abort while waiting for step_done
    en_a = 0;
    ts0 = n_ts_a;
    pulse_start_a();
    n = 0;
    while (!sreq_a && n < 50) begin tick(); n++; end
    check("a_saw_step_req", 32'(sreq_a), 1);
    tick();
    abort_a = 1;
    @(posedge clk); #1;
    abort_a = 0;
    check("a_abort_busy", 32'(busy_a), 0);
    check("a_abort_done", 32'(done_a), 0);
    check("a_abort_sc",   32'(sc_a), 0);
    tick(); tick();
    check("a_abort_no_ts", 32'(n_ts_a - ts0), 0);
    check("a_abort_stays", 32'(busy_a), 0);
    en_a = 1;

    // B: every step lands on cell 2, episodes end on the step limit
    ts0 = n_ts_b; ls0 = n_ls_b;
    pulse_start_b();
    wait_done_b("b_limit_done");
    check("b_limit_sc",   32'(sc_b), 4);
    check("b_limit_maze", 32'(maze_b), 2);
    check("b_limit_ep",   32'(ep_b), 3);
    check("b_limit_ts",   32'(n_ts_b - ts0), 3);
    check("b_limit_ls",   32'(n_ls_b - ls0), 1);
    check("b_limit_actq", 32'(actq_b), 3);
    tick();

    // B: goal reached exactly on the last allowed step
    tab_b[3] = 36;
    ts0 = n_ts_b; ls0 = n_ls_b;
    pulse_start_b();
    wait_done_b("b_goal_done");
    check("b_goal_sc",   32'(sc_b), 4);
    check("b_goal_maze", 32'(maze_b), 36);
    check("b_goal_ep",   32'(ep_b), 3);
    check("b_goal_ts",   32'(n_ts_b - ts0), 3);
    check("b_goal_ls",   32'(n_ls_b - ls0), 1);
    tick();

    // A: asynchronous reset while in UPDATE
    tab_a[0] = 7; tab_a[1] = 13; tab_a[2] = 19;
    pulse_start_a();
    n = 0;
    while (!(sc_a == 8'd2 && sd_a) && n < 100) begin tick(); n++; end
    check("a_pre_rst_sc", 32'(sc_a), 2);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("a_arst_maze", 32'(maze_a), 1);
    check("a_arst_sc",   32'(sc_a), 0);
    check("a_arst_actq", 32'(actq_a), 0);
    check("a_arst_busy", 32'(busy_a), 0);
    check("a_arst_ep",   32'(ep_a), 0);
    check("a_arst_sreq", 32'(sreq_a), 0);
    tick();
    rst = 1;
    tick(); tick(); tick();
    check("a_no_restart", 32'(busy_a), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
